bilinear_scaler_stream: RTL and testbench
=========================================

// Module: bilinear_scaler_stream
// PURPOSE
//  Next-generation SIMD image downscaler with run-time frame geometry (src/dst W,H latched at start).
//  Reads the source frame through a single synchronous memory read port, not a flat array input.
//  Selectable bilinear or nearest-neighbour mode; emits N-pixel raster-order beats on a valid/ready stream.
//  Sits between the frame buffer and the output packer; the datapath is internal (no Top_SIMD instance).
// PARAMETERS
//  N          4    lanes (pixels) per output beat
//  PIX_W      8    bits per pixel
//  FRAC       8    fractional bits of coordinate ratios (Q8.FRAC)
//  SRC_MAX    64   max source width/height; also limits dst
//  DIM_W      $clog2(SRC_MAX)+1   width of dimension ports (derived)
//  ADDR_W     $clog2(SRC_MAX*SRC_MAX)   memory address width (derived)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  start        in   1           begin frame; sampled only in IDLE
//  mode         in   1           0 = bilinear, 1 = nearest; latched at start
//  src_w,src_h  in   DIM_W       source size; latched at start
//  dst_w,dst_h  in   DIM_W       destination size; latched at start
//  ratio_x      in   8+FRAC      (src_w-1)/(dst_w-1) in Q8.FRAC, computed by software
//  ratio_y      in   8+FRAC      (src_h-1)/(dst_h-1) in Q8.FRAC
//  mem_rd_en    out  1           read strobe
//  mem_rd_addr  out  ADDR_W      y*src_w + x
//  mem_rd_data  in   PIX_W       valid exactly 1 cycle after mem_rd_en
//  out_valid    out  1           beat available
//  out_ready    in   1           sink accepts beat
//  out_data     out  N*PIX_W     lane k at [k*PIX_W +: PIX_W]
//  out_mask     out  N           1 = lane holds a real pixel
//  out_last     out  1           final beat of frame
//  busy         out  1           high from accepted start until done
//  done         out  1           1-cycle pulse after last beat handshake
//  cfg_err      out  1           sticky; cleared by next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, any time, async): all outputs 0, FSM->IDLE, in-flight frame abandoned; no partial beat emitted.
//  FSM states and transitions:
//   IDLE  -start-> CHECK: latch config, clear cfg_err.
//   CHECK -> ERR if dst_w<2 | dst_h<2 | dst_w>src_w | dst_h>src_h | src_w>SRC_MAX | src_h>SRC_MAX;
//         ERR: cfg_err<=1, return to IDLE, no reads, no done.
//         Otherwise -> FETCH with base_idx=0.
//   FETCH: one read per cycle. Bilinear: 4 per active lane (I00,I10,I01,I11 order), lane 0 first.
//          Nearest: 1 per active lane. Inactive lanes (idx>=dst_w*dst_h) issue no reads.
//   INTERP: 1 cycle; compute all lanes, register into out_data/out_mask/out_last -> EMIT.
//   EMIT: out_valid=1. While valid & !ready, out_data/out_mask/out_last held stable.
//         On handshake: if last beat -> DONE; else base_idx+=N -> FETCH.
//   DONE: done=1 for one cycle, busy<=0 -> IDLE.
//  Start while busy is ignored. A start with config that fails CHECK gives busy=1 for exactly 2 cycles.
//  Coordinates: idx=base_idx+k; i=idx/dst_w; j=idx%dst_w; xs=j*ratio_x; ys=i*ratio_y (Q8.FRAC, no overflow).
//  x_l=floor(xs), clamped to src_w-1. a=frac(xs).
//  x_h=x_l when a==0 or x_l>=src_w-1, else x_l+1. y uses the same rules with b.
//  Bilinear: top=I00*(2^F-a)+I10*a; bot=I01*(2^F-a)+I11*a;
//   p=(top*(2^F-b)+bot*b+2^(2F-1))>>2F, saturated to 2^PIX_W-1.
//  Nearest: x=x_l+(a>=2^(F-1)), clamped to src_w-1; y likewise; p=mem[y][x].
//  Inactive lanes: data 0, mask 0. Raster pixel order, lane 0 = lowest idx.
//  Bilinear latency per beat = 4*active+2 cycles, plus stall.
// TESTING
//  T1 4x4 src, pixel=60*x; dst 3x3, ratio 0x0180, mode 0 -> each row 0,90,180; beats=3; last mask 0001 with out_last.
//  T2 same frame, mode 1 -> each row 0,120,180; 1 read per lane (9 reads total).
//  T3 out_ready low 5 cycles during beat 2 -> out_data/mask stable, no extra reads, final image unchanged.
//  T4 dst_w=1 or dst_w>src_w -> cfg_err=1, mem_rd_en never set, done never pulses; next valid start clears cfg_err.
//  T5 rst_n low mid-FETCH -> outputs 0 same cycle; a fresh start then reproduces T1 exactly.
//  T6 64x64 all 255, dst 64x64 (ratio 0x0100) -> every pixel 255, no saturation wrap, 1024 beats.

Source files
------------

// File: rtl/bilinear_scaler_stream_if.sv
// Memory read port and output beat stream of the bilinear downscaler.
// master = scaler side, slave = frame buffer / output packer side.
interface bilinear_scaler_stream_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 12
);
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_rd_addr;
    logic [PIX_W-1:0]   mem_rd_data;
    logic               out_valid;
    logic               out_ready;
    logic [N*PIX_W-1:0] out_data;
    logic [N-1:0]       out_mask;
    logic               out_last;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_mask,
        output out_last
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_mask,
        input  out_last
    );
endinterface

// File: rtl/bilinear_scaler_stream.sv
// Streaming bilinear / nearest-neighbour downscaler: fetches taps through one synchronous
// read port, interpolates N lanes at once and emits raster-order beats on a valid/ready stream.
module bilinear_scaler_stream #(
    parameter int unsigned N       = 4,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned SRC_MAX = 64,
    parameter int unsigned DIM_W   = $clog2(SRC_MAX) + 1,
    parameter int unsigned ADDR_W  = $clog2(SRC_MAX * SRC_MAX)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic [DIM_W-1:0]         src_w,
    input  logic [DIM_W-1:0]         src_h,
    input  logic [DIM_W-1:0]         dst_w,
    input  logic [DIM_W-1:0]         dst_h,
    input  logic [7+FRAC:0]          ratio_x,
    input  logic [7+FRAC:0]          ratio_y,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    bilinear_scaler_stream_if.master bus
);
    localparam int unsigned RAT_W   = 8 + FRAC;
    localparam int unsigned XS_W    = DIM_W + RAT_W;
    localparam int unsigned INT_W   = XS_W - FRAC;
    localparam int unsigned LANE_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ACC_W   = 2 * FRAC + PIX_W + 2;
    localparam int unsigned ONE     = 1 << FRAC;
    localparam int unsigned HALF2   = 1 << (2 * FRAC - 1);
    localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;

    typedef enum logic [2:0] {
        StIdle, StCheck, StErr, StFetch, StInterp, StEmit, StDone
    } state_e;

    state_e             state_q;
    logic               mode_q;
    logic [DIM_W-1:0]   src_w_q, src_h_q, dst_w_q, dst_h_q;
    logic [RAT_W-1:0]   ratio_x_q, ratio_y_q;
    logic [DIM_W-1:0]   row_q, col_q;
    logic [LANE_W-1:0]  lane_q;
    logic [1:0]         sub_q;
    logic [N-1:0]       act_q;
    logic               last_q;
    logic [FRAC-1:0]    a_q [N];
    logic [FRAC-1:0]    b_q [N];
    logic               busy_q, done_q, cfg_err_q;
    logic               out_valid_q, out_last_q;
    logic [N*PIX_W-1:0] out_data_q;
    logic [N-1:0]       out_mask_q;
    logic               rd_pend_q;
    logic [LANE_W-1:0]  rd_lane_q;
    logic [1:0]         rd_sub_q;
    logic [PIX_W-1:0]   samp_q [N][4];
    logic [PIX_W-1:0]   samp_v [N][4];

    function automatic logic [DIM_W-1:0] clamp_floor(logic [XS_W-1:0] v, logic [DIM_W-1:0] lim);
        logic [INT_W-1:0] ip;
        ip = v[XS_W-1:FRAC];
        return (ip > INT_W'(lim)) ? lim : ip[DIM_W-1:0];
    endfunction

    function automatic logic [DIM_W-1:0] step_hi(logic [DIM_W-1:0] lo, logic [FRAC-1:0] f,
                                                 logic [DIM_W-1:0] lim);
        return (f == '0 || lo >= lim) ? lo : lo + DIM_W'(1);
    endfunction

    function automatic logic [DIM_W-1:0] round_near(logic [DIM_W-1:0] lo, logic up,
                                                    logic [DIM_W-1:0] lim);
        logic [DIM_W-1:0] r;
        r = lo + DIM_W'(up);
        return (r > lim) ? lim : r;
    endfunction

    // Source coordinates of the lane currently being fetched.
    logic [XS_W-1:0]  xs, ys;
    logic [FRAC-1:0]  frac_a, frac_b;
    logic [DIM_W-1:0] src_w_m1, src_h_m1;
    logic [DIM_W-1:0] x_l, x_h, x_n, y_l, y_h, y_n, sel_x, sel_y;

    assign src_w_m1 = src_w_q - DIM_W'(1);
    assign src_h_m1 = src_h_q - DIM_W'(1);
    assign xs       = XS_W'(col_q) * XS_W'(ratio_x_q);
    assign ys       = XS_W'(row_q) * XS_W'(ratio_y_q);
    assign frac_a   = xs[FRAC-1:0];
    assign frac_b   = ys[FRAC-1:0];
    assign x_l      = clamp_floor(xs, src_w_m1);
    assign y_l      = clamp_floor(ys, src_h_m1);
    assign x_h      = step_hi(x_l, frac_a, src_w_m1);
    assign y_h      = step_hi(y_l, frac_b, src_h_m1);
    assign x_n      = round_near(x_l, frac_a[FRAC-1], src_w_m1);
    assign y_n      = round_near(y_l, frac_b[FRAC-1], src_h_m1);

    // Tap order within a lane: I00, I10, I01, I11.
    always_comb begin
        sel_x = x_l;
        sel_y = y_l;
        if (mode_q) begin
            sel_x = x_n;
            sel_y = y_n;
        end else begin
            case (sub_q)
                2'd0:    ;
                2'd1:    sel_x = x_h;
                2'd2:    sel_y = y_h;
                default: begin
                    sel_x = x_h;
                    sel_y = y_h;
                end
            endcase
        end
    end

    assign bus.mem_rd_en   = (state_q == StFetch);
    assign bus.mem_rd_addr = ADDR_W'(sel_y) * ADDR_W'(src_w_q) + ADDR_W'(sel_x);

    logic             cfg_bad;
    logic             lane_done;
    logic             col_wrap;
    logic [DIM_W-1:0] next_col, next_row;

    assign cfg_bad = (dst_w_q < DIM_W'(2)) || (dst_h_q < DIM_W'(2)) ||
                     (dst_w_q > src_w_q) || (dst_h_q > src_h_q) ||
                     (src_w_q > DIM_W'(SRC_MAX)) || (src_h_q > DIM_W'(SRC_MAX));
    assign lane_done = mode_q || (sub_q == 2'd3);
    assign col_wrap  = ((col_q + DIM_W'(1)) == dst_w_q);
    assign next_col  = col_wrap ? '0 : col_q + DIM_W'(1);
    assign next_row  = col_wrap ? row_q + DIM_W'(1) : row_q;

    // The final tap lands during INTERP, so it is bypassed straight from the read port.
    always_comb begin
        samp_v = samp_q;
        if (rd_pend_q) begin
            samp_v[rd_lane_q][rd_sub_q] = bus.mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pend_q) begin
            samp_q[rd_lane_q][rd_sub_q] <= bus.mem_rd_data;
        end
    end

    logic [N*PIX_W-1:0] pix_all;

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [ACC_W-1:0] wa, wb, top, bot, acc;
        logic [PIX_W-1:0] pix;

        assign wa  = ACC_W'(ONE) - ACC_W'(a_q[k]);
        assign wb  = ACC_W'(ONE) - ACC_W'(b_q[k]);
        assign top = ACC_W'(samp_v[k][0]) * wa + ACC_W'(samp_v[k][1]) * ACC_W'(a_q[k]);
        assign bot = ACC_W'(samp_v[k][2]) * wa + ACC_W'(samp_v[k][3]) * ACC_W'(a_q[k]);
        assign acc = (top * wb + bot * ACC_W'(b_q[k]) + ACC_W'(HALF2)) >> (2 * FRAC);
        assign pix = mode_q ? samp_v[k][0] :
                     (acc > ACC_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : acc[PIX_W-1:0];
        assign pix_all[k*PIX_W +: PIX_W] = act_q[k] ? pix : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            src_w_q     <= '0;
            src_h_q     <= '0;
            dst_w_q     <= '0;
            dst_h_q     <= '0;
            ratio_x_q   <= '0;
            ratio_y_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            lane_q      <= '0;
            sub_q       <= '0;
            act_q       <= '0;
            last_q      <= 1'b0;
            for (int k = 0; k < N; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_lane_q   <= '0;
            rd_sub_q    <= '0;
        end else begin
            done_q    <= 1'b0;
            rd_pend_q <= (state_q == StFetch);
            rd_lane_q <= lane_q;
            rd_sub_q  <= sub_q;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q    <= mode;
                        src_w_q   <= src_w;
                        src_h_q   <= src_h;
                        dst_w_q   <= dst_w;
                        dst_h_q   <= dst_h;
                        ratio_x_q <= ratio_x;
                        ratio_y_q <= ratio_y;
                        cfg_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StCheck;
                    end
                end
                StCheck: begin
                    if (cfg_bad) begin
                        state_q <= StErr;
                    end else begin
                        row_q   <= '0;
                        col_q   <= '0;
                        lane_q  <= '0;
                        sub_q   <= '0;
                        act_q   <= '0;
                        state_q <= StFetch;
                    end
                end
                StErr: begin
                    cfg_err_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                StFetch: begin
                    if (lane_done) begin
                        act_q[lane_q] <= 1'b1;
                        a_q[lane_q]   <= frac_a;
                        b_q[lane_q]   <= frac_b;
                        sub_q         <= '0;
                        col_q         <= next_col;
                        row_q         <= next_row;
                        if (lane_q == LANE_W'(N - 1) || next_row == dst_h_q) begin
                            last_q  <= (next_row == dst_h_q);
                            state_q <= StInterp;
                        end else begin
                            lane_q <= lane_q + LANE_W'(1);
                        end
                    end else begin
                        sub_q <= sub_q + 2'd1;
                    end
                end
                StInterp: begin
                    out_data_q  <= pix_all;
                    out_mask_q  <= act_q;
                    out_last_q  <= last_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StEmit;
                end
                StEmit: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            lane_q  <= '0;
                            sub_q   <= '0;
                            act_q   <= '0;
                            state_q <= StFetch;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_bilinear_scaler_stream.sv
// Directed and randomized frames for bilinear_scaler_stream, checked against an arithmetic
// reference model of the scaling rules over a frame-buffer array.
module tb_bilinear_scaler_stream;
    localparam int N       = 4;
    localparam int PIX_W   = 8;
    localparam int FRAC    = 8;
    localparam int SRC_MAX = 64;
    localparam int DIM_W   = 7;
    localparam int ADDR_W  = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [DIM_W-1:0] src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
    logic [15:0]      ratio_x = '0, ratio_y = '0;
    logic             busy, done, cfg_err;

    bilinear_scaler_stream_if #(.N(N), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

    bilinear_scaler_stream #(
        .N(N), .PIX_W(PIX_W), .FRAC(FRAC), .SRC_MAX(SRC_MAX), .DIM_W(DIM_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
        .ratio_x(ratio_x), .ratio_y(ratio_y),
        .busy(busy), .done(done), .cfg_err(cfg_err), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [PIX_W-1:0] mem [4096];

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    int checks = 0;
    int errors = 0;
    int got_img [4096];
    int t1_img [9];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scaling rules applied directly to the frame buffer with integer arithmetic.
    function automatic int ref_pix(input int m, sw, sh, rx, ry, i, j);
        int xs, ys, xl, yl, xh, yh, a, b, xn, yn, top, bot, p;
        xs = j * rx;
        ys = i * ry;
        xl = xs >> FRAC;
        yl = ys >> FRAC;
        a  = xs % (1 << FRAC);
        b  = ys % (1 << FRAC);
        if (xl > sw - 1) xl = sw - 1;
        if (yl > sh - 1) yl = sh - 1;
        xh = (a == 0 || xl >= sw - 1) ? xl : xl + 1;
        yh = (b == 0 || yl >= sh - 1) ? yl : yl + 1;
        if (m != 0) begin
            xn = xl + ((a >= (1 << (FRAC - 1))) ? 1 : 0);
            yn = yl + ((b >= (1 << (FRAC - 1))) ? 1 : 0);
            if (xn > sw - 1) xn = sw - 1;
            if (yn > sh - 1) yn = sh - 1;
            return int'(mem[yn * sw + xn]);
        end
        top = int'(mem[yl * sw + xl]) * ((1 << FRAC) - a) + int'(mem[yl * sw + xh]) * a;
        bot = int'(mem[yh * sw + xl]) * ((1 << FRAC) - a) + int'(mem[yh * sw + xh]) * a;
        p = (top * ((1 << FRAC) - b) + bot * b + (1 << (2 * FRAC - 1))) >> (2 * FRAC);
        if (p > (1 << PIX_W) - 1) p = (1 << PIX_W) - 1;
        return p;
    endfunction

    task automatic fill_ramp(input int sw, sh);
        for (int y = 0; y < sh; y++)
            for (int x = 0; x < sw; x++) mem[y * sw + x] = PIX_W'(60 * x);
    endtask

    task automatic fill_rand(input int sw, sh);
        for (int y = 0; y < sh; y++)
            for (int x = 0; x < sw; x++) mem[y * sw + x] = PIX_W'($urandom_range(0, 255));
    endtask

    task automatic fill_const(input int sw, sh, v);
        for (int y = 0; y < sh; y++)
            for (int x = 0; x < sw; x++) mem[y * sw + x] = PIX_W'(v);
    endtask

    task automatic set_cfg(input int m, sw, sh, dw, dh, rx, ry);
        mode    = m[0];
        src_w   = DIM_W'(sw);
        src_h   = DIM_W'(sh);
        dst_w   = DIM_W'(dw);
        dst_h   = DIM_W'(dh);
        ratio_x = 16'(rx);
        ratio_y = 16'(ry);
    endtask

    // pol: 0 = always ready, 1 = random ready, 2 = stall 5 cycles on beat 1
    task automatic run_frame(input string tag, input int m, sw, sh, dw, dh, rx, ry,
                             input int pol, input bit expect_err);
        int total, nbeats, beat, rd, dn, bsy, stall_n, idx, p;
        bit fin, held;
        logic [N*PIX_W-1:0] hold_data, exp_data;
        logic [N-1:0]       hold_mask, exp_mask;
        total = dw * dh;
        nbeats = (total + N - 1) / N;
        beat = 0; rd = 0; dn = 0; bsy = 0; stall_n = 0;
        fin = 1'b0; held = 1'b0;
        hold_data = '0; hold_mask = '0;
        set_cfg(m, sw, sh, dw, dh, rx, ry);
        start = 1'b1;
        bus.out_ready = (pol == 0);
        for (int cyc = 0; cyc < 40000 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check({tag, " cfg_err cleared"}, cfg_err, 1'b0);
            if (busy) bsy++;
            if (bus.mem_rd_en) rd++;
            if (done) begin
                dn++;
                fin = 1'b1;
            end else if (cyc > 0 && !busy) begin
                fin = 1'b1;
            end
            if (held) begin
                check({tag, " hold valid"}, bus.out_valid, 1'b1);
                check({tag, " hold data"}, bus.out_data, hold_data);
                check({tag, " hold mask"}, bus.out_mask, hold_mask);
                check({tag, " no read in stall"}, bus.mem_rd_en, 1'b0);
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    exp_data = '0;
                    exp_mask = '0;
                    for (int k = 0; k < N; k++) begin
                        idx = beat * N + k;
                        if (idx < total) begin
                            p = ref_pix(m, sw, sh, rx, ry, idx / dw, idx % dw);
                            exp_data[k*PIX_W +: PIX_W] = p[PIX_W-1:0];
                            exp_mask[k] = 1'b1;
                            if (idx < 4096) got_img[idx] = int'(bus.out_data[k*PIX_W +: PIX_W]);
                        end
                    end
                    check({tag, " data"}, bus.out_data, exp_data);
                    check({tag, " mask"}, bus.out_mask, exp_mask);
                    check({tag, " last"}, bus.out_last, (beat == nbeats - 1));
                    beat++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hold_data = bus.out_data;
                    hold_mask = bus.out_mask;
                    stall_n++;
                end
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            case (pol)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = !(beat == 1 && stall_n < 5);
            endcase
        end
        check({tag, " finished in budget"}, fin, 1'b1);
        check({tag, " done count"}, dn, expect_err ? 0 : 1);
        check({tag, " cfg_err"}, cfg_err, expect_err);
        if (expect_err) begin
            check({tag, " reads"}, rd, 0);
            check({tag, " busy cycles"}, bsy, 2);
            check({tag, " beats"}, beat, 0);
        end else begin
            check({tag, " beats"}, beat, nbeats);
            check({tag, " reads"}, rd, ((m != 0) ? 1 : 4) * total);
            if (pol == 2) check({tag, " stall cycles"}, stall_n, 5);
        end
    endtask

    initial begin
        int row_exp [3];
        int row_near [3];
        int sw, sh, dw, dh, m;
        bit seen;
        row_exp[0] = 0;  row_exp[1] = 90;  row_exp[2] = 180;
        row_near[0] = 0; row_near[1] = 120; row_near[2] = 180;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset cfg_err", cfg_err, 1'b0);
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset rd_en", bus.mem_rd_en, 1'b0);
        check("reset out_data", bus.out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 bilinear 4x4 -> 3x3
        fill_ramp(4, 4);
        run_frame("t1", 0, 4, 4, 3, 3, 'h180, 'h180, 0, 1'b0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                check("t1 pixel", got_img[r * 3 + c], row_exp[c]);
                t1_img[r * 3 + c] = got_img[r * 3 + c];
            end

        // T2 nearest on the same frame
        run_frame("t2", 1, 4, 4, 3, 3, 'h180, 'h180, 0, 1'b0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) check("t2 pixel", got_img[r * 3 + c], row_near[c]);

        // T3 back-pressure during beat 1
        run_frame("t3", 0, 4, 4, 3, 3, 'h180, 'h180, 2, 1'b0);
        for (int i = 0; i < 9; i++) check("t3 image", got_img[i], t1_img[i]);

        // T4 rejected configurations, then a valid start clears cfg_err
        run_frame("t4 dst_w=1", 0, 4, 4, 1, 3, 'h300, 'h180, 0, 1'b1);
        run_frame("t4 dst_w>src_w", 0, 4, 4, 5, 3, 'h0c0, 'h180, 0, 1'b1);
        run_frame("t4 src_w>max", 0, 70, 4, 3, 3, 'h180, 'h180, 0, 1'b1);
        run_frame("t4 recover", 1, 4, 4, 3, 3, 'h180, 'h180, 1, 1'b0);

        // T5 asynchronous reset in the middle of FETCH
        set_cfg(0, 4, 4, 3, 3, 'h180, 'h180);
        start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (bus.mem_rd_en) seen = 1'b1;
        end
        check("t5 fetch reached", seen, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 rd_en", bus.mem_rd_en, 1'b0);
        check("t5 busy", busy, 1'b0);
        check("t5 out_valid", bus.out_valid, 1'b0);
        check("t5 out_mask", bus.out_mask, '0);
        check("t5 done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame("t5 rerun", 0, 4, 4, 3, 3, 'h180, 'h180, 0, 1'b0);
        for (int i = 0; i < 9; i++) check("t5 image", got_img[i], t1_img[i]);

        // Randomized geometry, content, mode and back-pressure
        for (int t = 0; t < 6; t++) begin
            sw = $urandom_range(2, 12);
            sh = $urandom_range(2, 12);
            dw = $urandom_range(2, sw);
            dh = $urandom_range(2, sh);
            m  = $urandom_range(0, 1);
            fill_rand(sw, sh);
            run_frame("rand", m, sw, sh, dw, dh, ((sw - 1) << FRAC) / (dw - 1),
                      ((sh - 1) << FRAC) / (dh - 1), 1, 1'b0);
        end

        // T6 full-size flat white frame at 1:1
        fill_const(64, 64, 255);
        run_frame("t6", 0, 64, 64, 64, 64, 'h100, 'h100, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
